mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Shares one single-port, synchronous-read block RAM (the BIOS/IMEM-style memory) between the CPU instruction-fetch port and the data-access port.
- Each requester uses a valid/ready request channel plus a 1-cycle-later response strobe.
- Data accesses have priority. A starvation counter guarantees forward progress for instruction fetch.
- Sits between the Riscv151 pipeline stages and the memory instance.

Parameters:
- ADDR_WIDTH, 14, word-address width of the shared memory.
- DATA_WIDTH, 32, data word width.
- STARVE_LIMIT, 4, consecutive lost cycles after which a waiting fetch wins. 0 means pure fixed data priority, no override.

Ports:
- clk  in  1  sole clock; all state updates on posedge clk.
- rst  in  1  synchronous, active-low reset; sampled on posedge clk.
- i_req_valid  in  1  fetch request pending.
- i_req_ready  out  1  fetch request accepted this cycle.
- i_addr  in  ADDR_WIDTH  fetch word address.
- i_resp_valid  out  1  fetch read data valid.
- i_rdata  out  DATA_WIDTH  fetch read data.
- d_req_valid  in  1  data request pending.
- d_req_ready  out  1  data request accepted this cycle.
- d_addr  in  ADDR_WIDTH  data word address.
- d_we  in  4  byte write enables; 0000 means read.
- d_wdata  in  DATA_WIDTH  write data.
- d_resp_valid  out  1  data access completed (read data valid, or write ack).
- d_rdata  out  DATA_WIDTH  data read data.
- mem_en  out  1  memory enable.
- mem_we  out  4  memory byte write enables.
- mem_addr  out  ADDR_WIDTH  memory address.
- mem_din  out  DATA_WIDTH  memory write data.
- mem_dout  in  DATA_WIDTH  memory read data; valid the cycle after mem_en.
- starve_cnt  out  3  current starvation count, for debug and verification.

Behaviour:
- Reset (rst==0 at posedge):
  - i_resp_valid=0, d_resp_valid=0, starve_cnt=0, response tags cleared.
  - While rst==0, i_req_ready=d_req_ready=0, mem_en=0, mem_we=0; no request is accepted.
- Grant (combinational, rst==1):
  - override = (STARVE_LIMIT!=0) && (starve_cnt==STARVE_LIMIT) && i_req_valid.
  - grant_d = d_req_valid && !override.
  - grant_i = i_req_valid && !grant_d.
  - d_req_ready=grant_d, i_req_ready=grant_i. Ready depends only on valid and state; no combinational path from ready back to valid.
- Memory drive:
  - mem_en = grant_i|grant_d.
  - mem_addr = grant_d ? d_addr : i_addr.
  - mem_we = grant_d ? d_we : 0.
  - mem_din = d_wdata (don't-care when not writing).
  - With no grant: mem_en=0, mem_we=0.
- Response (fixed latency 1, fully pipelined):
  - i_resp_valid <= grant_i; d_resp_valid <= grant_d.
  - i_rdata=d_rdata=mem_dout combinationally.
  - d_rdata is meaningful only for reads. Writes still produce a d_resp_valid ack.
  - One accept per cycle total; back-to-back accepts on consecutive cycles are allowed.
- Starvation counter:
  - If i_req_valid && !grant_i: increment, saturating at STARVE_LIMIT.
  - If grant_i or !i_req_valid: clear to 0.
  - When STARVE_LIMIT==0 the counter stays 0.
- Simultaneous requests: data wins unless override; after an override win, the counter clears, so data wins again next cycle.
- Requesters hold valid and payload stable until ready. The arbiter does not register requests; a dropped valid simply withdraws the request.
- Reset mid-operation: a request granted the cycle before rst asserts has its resp_valid cleared by reset. Its response is lost, and the requester must reissue.
- Write/read same address on consecutive cycles: the read returns the newly written data (memory is read-after-write ordered by cycle).

Test Plan:
- Reset: hold rst=0 for 10 cycles with both valids=1 -> mem_en=0, both readies=0, both resp_valid=0, starve_cnt=0 throughout. First cycle after release: d_req_ready=1.
- Single fetch: preload mem[5]=0x00000013; i_req_valid=1, i_addr=5 for one cycle -> i_req_ready=1 same cycle; next cycle i_resp_valid=1, i_rdata=0x00000013, d_resp_valid=0.
- Data write then read: d_we=1111, d_addr=10, d_wdata=300; then read addr 10 -> two d_resp_valid pulses on consecutive cycles, second with d_rdata=300. Byte write d_we=0001, wdata=0xFF, then read -> 0x000001FF.
- Contention (STARVE_LIMIT=4): both valids held high -> d granted 4 cycles (starve_cnt 1,2,3,4), i granted on cycle 5, d on cycle 6 with counter back to 0. Pattern repeats every 5 cycles.
- STARVE_LIMIT=0: both held high for 20 cycles -> i_req_ready never asserts, starve_cnt stays 0.
- Reset mid-flight: grant fetch, assert rst=0 the next cycle -> i_resp_valid=0 on that edge. After release, the reissued fetch returns correct data with 1-cycle latency.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - data-priority arbiter sharing one sync-read RAM between fetch and data ports
//
// Purpose:
//   Shares a single-port, synchronous-read block RAM between the instruction-fetch
//   requester and the data-access requester. Data accesses normally win. A
//   starvation counter forces a waiting fetch through after STARVE_LIMIT lost cycles.
//   Responses come back exactly one cycle after acceptance, fully pipelined.
//
// Ports:
//   clk, rst                      clock and synchronous active-low reset
//   i_req_valid/i_req_ready       fetch request handshake, i_addr word address
//   i_resp_valid/i_rdata          fetch response strobe and read data
//   d_req_valid/d_req_ready       data request handshake, d_addr/d_we/d_wdata payload
//   d_resp_valid/d_rdata          data response strobe (read data or write ack)
//   mem_en/mem_we/mem_addr/mem_din/mem_dout   shared memory interface
//   starve_cnt                    current fetch starvation count (debug)

module mem_port_arbiter #(
    parameter int ADDR_WIDTH   = 14,
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,

    input  logic                  i_req_valid,
    output logic                  i_req_ready,
    input  logic [ADDR_WIDTH-1:0] i_addr,
    output logic                  i_resp_valid,
    output logic [DATA_WIDTH-1:0] i_rdata,

    input  logic                  d_req_valid,
    output logic                  d_req_ready,
    input  logic [ADDR_WIDTH-1:0] d_addr,
    input  logic [3:0]            d_we,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    output logic                  d_resp_valid,
    output logic [DATA_WIDTH-1:0] d_rdata,

    output logic                  mem_en,
    output logic [3:0]            mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    input  logic [DATA_WIDTH-1:0] mem_dout,

    output logic [2:0]            starve_cnt
);

    localparam logic [2:0] STARVE_MAX = 3'(STARVE_LIMIT);

    logic [2:0] starve_cnt_q;
    logic [2:0] starve_cnt_d;
    logic       i_resp_valid_q;
    logic       i_resp_valid_d;
    logic       d_resp_valid_q;
    logic       d_resp_valid_d;

    logic       override;
    logic       grant_d;
    logic       grant_i;

    // Grants depend only on the valids and the counter, never on ready, so no
    // combinational loop can form through a requester. Reset blocks all grants.
    always_comb begin
        override = (STARVE_LIMIT != 0) && (starve_cnt_q == STARVE_MAX) && i_req_valid;
        grant_d  = rst && d_req_valid && !override;
        grant_i  = rst && i_req_valid && !grant_d;
    end

    always_comb begin
        d_req_ready = grant_d;
        i_req_ready = grant_i;

        mem_en   = grant_i | grant_d;
        mem_addr = grant_d ? d_addr : i_addr;
        mem_we   = grant_d ? d_we : 4'b0000;
        mem_din  = d_wdata;

        // The RAM output is shared; the response strobes say who owns it.
        i_rdata  = mem_dout;
        d_rdata  = mem_dout;
    end

    always_comb begin
        i_resp_valid_d = grant_i;
        d_resp_valid_d = grant_d;

        // Counts consecutive cycles a pending fetch lost; any fetch grant or an
        // idle fetch port clears it. A zero limit keeps it pinned at zero.
        starve_cnt_d = 3'd0;
        if ((STARVE_LIMIT != 0) && i_req_valid && !grant_i) begin
            if (starve_cnt_q == STARVE_MAX) begin
                starve_cnt_d = STARVE_MAX;
            end else begin
                starve_cnt_d = starve_cnt_q + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            starve_cnt_q   <= 3'd0;
            i_resp_valid_q <= 1'b0;
            d_resp_valid_q <= 1'b0;
        end else begin
            starve_cnt_q   <= starve_cnt_d;
            i_resp_valid_q <= i_resp_valid_d;
            d_resp_valid_q <= d_resp_valid_d;
        end
    end

    assign i_resp_valid = i_resp_valid_q;
    assign d_resp_valid = d_resp_valid_q;
    assign starve_cnt   = starve_cnt_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter

module tb_mem_port_arbiter;

    localparam int AW    = 14;
    localparam int DW    = 32;
    localparam int LIMIT = 4;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_req_valid;
    logic [AW-1:0] i_addr;
    logic          d_req_valid;
    logic [AW-1:0] d_addr;
    logic [3:0]    d_we;
    logic [DW-1:0] d_wdata;

    logic          i_req_ready, i_resp_valid, d_req_ready, d_resp_valid;
    logic [DW-1:0] i_rdata, d_rdata;
    logic          mem_en;
    logic [3:0]    mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout = '0;
    logic [2:0]    starve_cnt;

    logic          z_i_req_ready, z_i_resp_valid, z_d_req_ready, z_d_resp_valid;
    logic [DW-1:0] z_i_rdata, z_d_rdata;
    logic          z_mem_en;
    logic [3:0]    z_mem_we;
    logic [AW-1:0] z_mem_addr;
    logic [DW-1:0] z_mem_din;
    logic [DW-1:0] z_mem_dout = 32'h0;
    logic [2:0]    z_starve_cnt;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_addr(i_addr),
        .i_resp_valid(i_resp_valid), .i_rdata(i_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_resp_valid(d_resp_valid), .d_rdata(d_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din),
        .mem_dout(mem_dout), .starve_cnt(starve_cnt)
    );

    mem_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .STARVE_LIMIT(0)) dut_nolimit (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(z_i_req_ready), .i_addr(i_addr),
        .i_resp_valid(z_i_resp_valid), .i_rdata(z_i_rdata),
        .d_req_valid(d_req_valid), .d_req_ready(z_d_req_ready), .d_addr(d_addr),
        .d_we(d_we), .d_wdata(d_wdata), .d_resp_valid(z_d_resp_valid), .d_rdata(z_d_rdata),
        .mem_en(z_mem_en), .mem_we(z_mem_we), .mem_addr(z_mem_addr), .mem_din(z_mem_din),
        .mem_dout(z_mem_dout), .starve_cnt(z_starve_cnt)
    );

    // Block RAM behind the main DUT: synchronous read, byte write enables.
    logic [DW-1:0] ram [0:DEPTH-1];

    always @(posedge clk) begin
        if (mem_en) begin
            mem_dout <= ram[mem_addr];
            for (int b = 0; b < 4; b++) begin
                if (mem_we[b]) ram[mem_addr][8*b +: 8] = mem_din[8*b +: 8];
            end
        end
    end

    // Reference model: who must win, what each response must carry.
    logic [DW-1:0] ref_mem [0:DEPTH-1];
    int            wait_cnt   = 0;
    bit            exp_iresp  = 1'b0;
    bit            exp_dresp  = 1'b0;
    bit            exp_dread  = 1'b0;
    logic [DW-1:0] exp_rdata  = '0;

    function automatic void who_wins(input bit rs, input bit iv, input bit dv, input int w,
                                     output bit fetch_wins, output bit data_wins);
        fetch_wins = rs && iv && (!dv || (LIMIT > 0 && w >= LIMIT));
        data_wins  = rs && dv && !fetch_wins;
    endfunction

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        bit fw, dw;
        who_wins(rst, i_req_valid, d_req_valid, wait_cnt, fw, dw);
        if (!rst) begin
            wait_cnt  = 0;
            exp_iresp = 1'b0;
            exp_dresp = 1'b0;
        end else begin
            exp_iresp = fw;
            exp_dresp = dw;
            exp_dread = dw && (d_we == 4'b0000);
            if (fw) exp_rdata = ref_mem[i_addr];
            if (dw) begin
                exp_rdata = ref_mem[d_addr];
                for (int b = 0; b < 4; b++) begin
                    if (d_we[b]) ref_mem[d_addr][8*b +: 8] = d_wdata[8*b +: 8];
                end
            end
            if (i_req_valid && !fw) wait_cnt = (wait_cnt + 1 > LIMIT) ? LIMIT : wait_cnt + 1;
            else                    wait_cnt = 0;
        end
    end

    always @(negedge clk) begin
        bit fw, dw;
        who_wins(rst, i_req_valid, d_req_valid, wait_cnt, fw, dw);
        chk("i_req_ready", 32'(i_req_ready), 32'(fw));
        chk("d_req_ready", 32'(d_req_ready), 32'(dw));
        chk("mem_en", 32'(mem_en), 32'(fw | dw));
        chk("mem_we", 32'(mem_we), dw ? 32'(d_we) : 32'h0);
        if (fw || dw) chk("mem_addr", 32'(mem_addr), dw ? 32'(d_addr) : 32'(i_addr));
        if (dw && d_we != 4'b0000) chk("mem_din", mem_din, d_wdata);
        chk("starve_cnt", 32'(starve_cnt), 32'(wait_cnt));
        chk("i_resp_valid", 32'(i_resp_valid), 32'(exp_iresp));
        chk("d_resp_valid", 32'(d_resp_valid), 32'(exp_dresp));
        if (exp_iresp) chk("i_rdata", i_rdata, exp_rdata);
        if (exp_dresp && exp_dread) chk("d_rdata", d_rdata, exp_rdata);
        chk("nolimit_i_req_ready", 32'(z_i_req_ready), 32'(rst && i_req_valid && !d_req_valid));
        chk("nolimit_starve_cnt", 32'(z_starve_cnt), 32'h0);
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit iv, input int ia, input bit dv, input int da,
                         input logic [3:0] we, input logic [DW-1:0] wd);
        i_req_valid = iv;
        i_addr      = AW'(ia);
        d_req_valid = dv;
        d_addr      = AW'(da);
        d_we        = we;
        d_wdata     = wd;
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            ram[k]     = 32'(k) * 32'h9E37_79B1;
            ref_mem[k] = 32'(k) * 32'h9E37_79B1;
        end
        ram[5]     = 32'h0000_0013;
        ref_mem[5] = 32'h0000_0013;

        rst = 1'b0;
        drive(1, 21, 1, 20, 4'b0000, 32'h0);

        // Reset held with both requesters asking.
        for (int c = 0; c < 10; c++) begin
            next_cycle();
            @(negedge clk);
            chk("rst_mem_en", 32'(mem_en), 32'h0);
            chk("rst_readies", 32'({i_req_ready, d_req_ready}), 32'h0);
            chk("rst_resp", 32'({i_resp_valid, d_resp_valid}), 32'h0);
            chk("rst_starve", 32'(starve_cnt), 32'h0);
        end

        // Release into contention: data wins four times, then fetch, period 5.
        next_cycle();
        rst = 1'b1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            chk("cont_starve", 32'(starve_cnt), 32'(c % 5));
            chk("cont_i_ready", 32'(i_req_ready), 32'((c % 5) == 4));
            chk("cont_d_ready", 32'(d_req_ready), 32'((c % 5) != 4));
            chk("nolim_i_ready", 32'(z_i_req_ready), 32'h0);
            next_cycle();
        end

        drive(0, 0, 0, 0, 4'b0000, 32'h0);
        next_cycle();

        // Single fetch of the preloaded word.
        drive(1, 5, 0, 0, 4'b0000, 32'h0);
        @(negedge clk);
        chk("fetch_ready", 32'(i_req_ready), 32'h1);
        next_cycle();
        drive(0, 0, 0, 0, 4'b0000, 32'h0);
        @(negedge clk);
        chk("fetch_resp", 32'(i_resp_valid), 32'h1);
        chk("fetch_rdata", i_rdata, 32'h0000_0013);
        chk("fetch_no_dresp", 32'(d_resp_valid), 32'h0);
        next_cycle();

        // Full write, then read back on the next cycle.
        drive(0, 0, 1, 10, 4'b1111, 32'd300);
        next_cycle();
        drive(0, 0, 1, 10, 4'b0000, 32'h0);
        @(negedge clk);
        chk("wr_ack", 32'(d_resp_valid), 32'h1);
        next_cycle();
        drive(0, 0, 0, 0, 4'b0000, 32'h0);
        @(negedge clk);
        chk("rd_resp", 32'(d_resp_valid), 32'h1);
        chk("rd_data", d_rdata, 32'd300);
        next_cycle();

        // Low-byte write merges into the existing word.
        drive(0, 0, 1, 10, 4'b0001, 32'h0000_00FF);
        next_cycle();
        drive(0, 0, 1, 10, 4'b0000, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 4'b0000, 32'h0);
        @(negedge clk);
        chk("byte_rd_data", d_rdata, 32'h0000_01FF);
        next_cycle();

        // Reset lands the cycle after a fetch grant; its response is dropped.
        drive(1, 5, 0, 0, 4'b0000, 32'h0);
        @(negedge clk);
        chk("mid_grant", 32'(i_req_ready), 32'h1);
        next_cycle();
        drive(0, 0, 0, 0, 4'b0000, 32'h0);
        rst = 1'b0;
        next_cycle();
        @(negedge clk);
        chk("mid_resp_cleared", 32'(i_resp_valid), 32'h0);
        next_cycle();
        rst = 1'b1;
        drive(1, 10, 0, 0, 4'b0000, 32'h0);
        next_cycle();
        drive(0, 0, 0, 0, 4'b0000, 32'h0);
        @(negedge clk);
        chk("reissue_resp", 32'(i_resp_valid), 32'h1);
        chk("reissue_rdata", i_rdata, 32'h0000_01FF);
        next_cycle();
        next_cycle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

endmodule
